llr_node_stage: RTL and testbench

//   Registered LLR processing stage for the polar SC decoder datapath. Consumes
//   8-bit two's-complement LLR pairs and produces one updated LLR per pair:
//   f-node (min-sum) or g-node (sum/difference selected by the partial-sum bit).

---
 rtl/llr_node_stage.sv | 138 +++++++++++++
 tb/tb_llr_node_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_node_stage.sv
// Polar SC decoder LLR stage: f-node (min-sum) / g-node (sum/diff),
// saturated, two-stage valid/ready pipeline with frame-last tagging.
module llr_node_stage #(
   parameter int W       = 8,
   parameter int N_PAIRS = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     llr_a,
   input  logic [W-1:0]     llr_b,
   input  logic             mode,
   input  logic             u_bit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     llr_out,
   output logic             out_last,
   output logic [CNT_W-1:0] sat_cnt
);

   localparam int PW = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
   localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W:0] GMAX = (W+1)'(2**(W-1) - 1);
   localparam logic signed [W:0] GMIN = -GMAX;
   localparam logic [PW-1:0] LAST_IDX = PW'(N_PAIRS - 1);

   logic en;
   logic acc;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign acc      = in_valid && en;

   // magnitude with the most-negative code clamped to the positive max
   function automatic logic [W-1:0] mag(input logic [W-1:0] v);
      if (v == MINN)
         return MAXP;
      else if (v[W-1])
         return -v;
      else
         return v;
   endfunction

   logic signed [W:0] a_x;
   logic signed [W:0] b_x;
   logic signed [W:0] sum_d;
   logic signed [W:0] diff_d;
   logic              clf_d;
   logic [PW-1:0]     pcnt;
   logic              last_d;

   assign a_x    = {llr_a[W-1], llr_a};
   assign b_x    = {llr_b[W-1], llr_b};
   assign sum_d  = b_x + a_x;
   assign diff_d = b_x - a_x;
   assign clf_d  = (llr_a == MINN) || (llr_b == MINN);
   assign last_d = (pcnt == LAST_IDX);

   logic              s1_v;
   logic signed [W:0] s1_sum;
   logic signed [W:0] s1_diff;
   logic [W-1:0]      s1_ma;
   logic [W-1:0]      s1_mb;
   logic              s1_clf;
   logic              s1_sgn;
   logic              s1_mode;
   logic              s1_u;
   logic              s1_last;

   logic signed [W:0] g_v;
   logic              g_hi;
   logic              g_lo;
   logic [W-1:0]      g_res;
   logic [W-1:0]      f_m;
   logic [W-1:0]      f_res;
   logic [W-1:0]      res;
   logic              clamp;

   always_comb begin
      g_v   = s1_u ? s1_diff : s1_sum;
      g_hi  = g_v > GMAX;
      g_lo  = g_v < GMIN;
      g_res = g_v[W-1:0];
      if (g_hi)
         g_res = MAXP;
      else if (g_lo)
         g_res = -MAXP;
      f_m   = (s1_ma < s1_mb) ? s1_ma : s1_mb;
      f_res = s1_sgn ? -f_m : f_m;
      res   = s1_mode ? g_res : f_res;
      clamp = s1_mode ? (g_hi || g_lo) : s1_clf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt      <= '0;
         s1_v      <= 1'b0;
         s1_sum    <= '0;
         s1_diff   <= '0;
         s1_ma     <= '0;
         s1_mb     <= '0;
         s1_clf    <= 1'b0;
         s1_sgn    <= 1'b0;
         s1_mode   <= 1'b0;
         s1_u      <= 1'b0;
         s1_last   <= 1'b0;
         out_valid <= 1'b0;
         llr_out   <= '0;
         out_last  <= 1'b0;
         sat_cnt   <= '0;
      end else if (en) begin
         s1_v <= in_valid;
         if (acc) begin
            pcnt    <= last_d ? '0 : pcnt + 1'b1;
            s1_sum  <= sum_d;
            s1_diff <= diff_d;
            s1_ma   <= mag(llr_a);
            s1_mb   <= mag(llr_b);
            s1_clf  <= clf_d;
            s1_sgn  <= llr_a[W-1] ^ llr_b[W-1];
            s1_mode <= mode;
            s1_u    <= u_bit;
            s1_last <= last_d;
         end
         out_valid <= s1_v;
         if (s1_v) begin
            llr_out  <= res;
            out_last <= s1_last;
            if (clamp && (sat_cnt != '1))
               sat_cnt <= sat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_llr_node_stage.sv
// Scoreboard bench for llr_node_stage: randomized pairs, arithmetic
// reference model, second instance with a 2-bit saturation counter.
module tb_llr_node_stage;

   localparam int W    = 8;
   localparam int MAXV = 2**(W-1) - 1;

   typedef struct {
      int llr;
      bit last;
      int sat;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         in_ready_s;
   logic [W-1:0] llr_a = '0;
   logic [W-1:0] llr_b = '0;
   logic         mode = 1'b0;
   logic         u_bit = 1'b0;
   logic         out_valid;
   logic         out_valid_s;
   logic         out_ready = 1'b1;
   logic [W-1:0] llr_out;
   logic [W-1:0] llr_out_s;
   logic         out_last;
   logic         out_last_s;
   logic [15:0]  sat_cnt;
   logic [1:0]   sat_cnt_s;

   llr_node_stage #(.W(W), .N_PAIRS(16), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .llr_a(llr_a), .llr_b(llr_b), .mode(mode), .u_bit(u_bit),
      .out_valid(out_valid), .out_ready(out_ready), .llr_out(llr_out),
      .out_last(out_last), .sat_cnt(sat_cnt)
   );

   llr_node_stage #(.W(W), .N_PAIRS(16), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .llr_a(llr_a), .llr_b(llr_b), .mode(mode), .u_bit(u_bit),
      .out_valid(out_valid_s), .out_ready(out_ready), .llr_out(llr_out_s),
      .out_last(out_last_s), .sat_cnt(sat_cnt_s)
   );

   always #5 clk = ~clk;

   int   passed = 0;
   int   total = 0;
   exp_t q[$];
   int   m_sat = 0;
   int   m_pair = 0;
   int   rmode = 0;
   int   phase = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp)
         passed++;
      else
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic void model(input int a, input int b, input bit md,
                                 input bit u, output int r, output bit s);
      int v;
      int ma;
      int mb;
      int m;
      s = 1'b0;
      if (md) begin
         v = u ? b - a : b + a;
         if (v > MAXV) begin
            r = MAXV;
            s = 1'b1;
         end else if (v < -MAXV) begin
            r = -MAXV;
            s = 1'b1;
         end else begin
            r = v;
         end
      end else begin
         ma = (a < 0) ? -a : a;
         mb = (b < 0) ? -b : b;
         if (ma > MAXV) begin
            ma = MAXV;
            s = 1'b1;
         end
         if (mb > MAXV) begin
            mb = MAXV;
            s = 1'b1;
         end
         m = (ma < mb) ? ma : mb;
         r = ((a < 0) != (b < 0)) ? -m : m;
      end
   endfunction

   // stimulus side: record the expected response of every accepted pair
   always @(negedge clk) begin
      exp_t e;
      int   r;
      bit   s;
      if (rst) begin
         q.delete();
         m_sat = 0;
         m_pair = 0;
      end else if (in_valid && in_ready) begin
         model(int'($signed(llr_a)), int'($signed(llr_b)), mode, u_bit, r, s);
         if (s && m_sat < 65535)
            m_sat++;
         e.llr = r;
         e.last = (m_pair == 15);
         e.sat = m_sat;
         m_pair = (m_pair + 1) % 16;
         q.push_back(e);
      end
   end

   bit           prev_rst = 1'b1;
   bit           hold_prev = 1'b0;
   logic [W-1:0] hold_llr;
   logic         hold_last;

   // monitor: compare whenever a result is consumed
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (prev_rst) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_llr_out", int'(llr_out), 0);
            chk("rst_out_last", int'(out_last), 0);
            chk("rst_sat_cnt", int'(sat_cnt), 0);
            chk("rst_out_valid_s", int'(out_valid_s), 0);
         end
         chk("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
         chk("in_ready_s", int'(in_ready_s), int'(in_ready));
         if (hold_prev) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_llr", int'(llr_out), int'(hold_llr));
            chk("hold_last", int'(out_last), int'(hold_last));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               chk("llr_out", int'($signed(llr_out)), e.llr);
               chk("out_last", int'(out_last), int'(e.last));
               chk("sat_cnt", int'(sat_cnt), e.sat);
               chk("out_valid_s", int'(out_valid_s), 1);
               chk("llr_out_s", int'($signed(llr_out_s)), e.llr);
               chk("sat_cnt_s", int'(sat_cnt_s), (e.sat > 3) ? 3 : e.sat);
            end
         end
         hold_prev = out_valid && !out_ready;
         hold_llr  = llr_out;
         hold_last = out_last;
      end else begin
         hold_prev = 1'b0;
      end
      prev_rst = rst;
   end

   always @(posedge clk) begin
      #1;
      case (rmode)
         1: begin
            out_ready = (phase == 0);
            phase = (phase + 1) % 3;
         end
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   task automatic send(input int a, input int b, input bit md, input bit u);
      bit acc;
      bit done;
      in_valid = 1'b1;
      llr_a = W'(a);
      llr_b = W'(b);
      mode = md;
      u_bit = u;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         done = acc;
      end
      if (!done)
         chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", int'(n < 500), 1);
   endtask

   function automatic int rnd_llr();
      int k;
      k = $urandom_range(0, 7);
      if (k == 0) return -128;
      if (k == 1) return 127;
      if (k == 2) return 0;
      return int'($urandom_range(0, 255)) - 128;
   endfunction

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      send(50, 60, 1, 0);
      send(100, 100, 1, 0);
      send(127, -1, 1, 1);
      send(-20, 35, 0, 0);
      send(-128, -128, 0, 0);
      send(0, -5, 0, 0);
      drain();
      chk("sat_after_directed", int'(sat_cnt), 3);

      do_reset();
      rmode = 1;
      phase = 0;
      for (int i = 0; i < 40; i++)
         send(rnd_llr(), rnd_llr(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      drain();
      rmode = 0;

      do_reset();
      for (int i = 0; i < 5; i++)
         send(i * 3, 7 - i, 1, 0);
      do_reset();
      for (int i = 0; i < 16; i++)
         send(i - 8, 2 * i, 0, 0);
      drain();

      do_reset();
      for (int i = 0; i < 5; i++)
         send(100, 90 + i, 1, 0);
      drain();
      chk("sat_cnt_small_final", int'(sat_cnt_s), 3);
      chk("sat_cnt_final", int'(sat_cnt), 5);

      rmode = 2;
      for (int i = 0; i < 300; i++) begin
         send(rnd_llr(), rnd_llr(), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 2));
      end
      drain();
      rmode = 0;
      idle(3);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
